// File: rtl/dmem_pkg.sv
// Shared definitions for the dual-core data-memory arbiter: FSM encoding,
// port identifiers and default widths.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_DEPTH_LOG2 = 8;

endpackage

// File: rtl/dual_core_data_arbiter_if.sv
// One core's data-memory request port (MEMREAD/MEMWR, address, write data,
// registered read data and completion pulse).
interface dual_core_data_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output rd, wr, addr, wdata, input rdata, ack);
    modport slave  (input rd, wr, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dmem_store.sv
// Single-port data storage with synchronous read; contents are never reset.
module dmem_store #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/dual_core_data_arbiter.sv
// Round-robin arbiter serving two core data ports against one storage array.
// Define ARB_STATS_EN to add saturating per-port grant counters.
module dual_core_data_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                      clk,
    input  logic                      reset,
    dual_core_data_arbiter_if.slave   core0,
    dual_core_data_arbiter_if.slave   core1,
`ifdef ARB_STATS_EN
    output logic [15:0]               grant_cnt0,
    output logic [15:0]               grant_cnt1,
`endif
    output logic                      busy
);
    state_t                state;
    logic                  rr_ptr;
    logic                  win_id;
    logic                  win_wr;
    logic [DEPTH_LOG2-1:0] win_addr;
    logic [DATA_W-1:0]     win_wdata;

    logic                  req0;
    logic                  req1;
    logic                  sel_id;
    logic                  sel_wr;
    logic [ADDR_W-1:0]     sel_addr_full;
    logic [DEPTH_LOG2-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  addr_hi_unused;

    logic                  store_we;
    logic [DEPTH_LOG2-1:0] store_addr;
    logic [DATA_W-1:0]     store_rdata;

    always_comb begin
        req0          = core0.rd | core0.wr;
        req1          = core1.rd | core1.wr;
        sel_id        = PORT0;
        if (req0 && req1) begin
            sel_id = rr_ptr;
        end else if (req1) begin
            sel_id = PORT1;
        end
        sel_wr        = (sel_id == PORT1) ? core1.wr    : core0.wr;
        sel_addr_full = (sel_id == PORT1) ? core1.addr  : core0.addr;
        sel_wdata     = (sel_id == PORT1) ? core1.wdata : core0.wdata;
        sel_addr      = sel_addr_full[DEPTH_LOG2-1:0];
    end

    // Upper address bits alias onto the low words by design.
    assign addr_hi_unused = ^sel_addr_full[ADDR_W-1:DEPTH_LOG2];

    // The store's read register is loaded on the grant edge so the word is
    // ready to be copied into the winner's rdata at the end of BUSY.
    assign store_addr = (state == IDLE) ? sel_addr : win_addr;
    assign store_we   = (state == BUSY) && win_wr;

    dmem_store #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .addr  (store_addr),
        .wdata (win_wdata),
        .rdata (store_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= PORT0;
            win_id      <= PORT0;
            win_wr      <= 1'b0;
            win_addr    <= '0;
            win_wdata   <= '0;
            core0.ack   <= 1'b0;
            core1.ack   <= 1'b0;
            core0.rdata <= '0;
            core1.rdata <= '0;
            busy        <= 1'b0;
`ifdef ARB_STATS_EN
            grant_cnt0  <= '0;
            grant_cnt1  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    core0.ack <= 1'b0;
                    core1.ack <= 1'b0;
                    if (req0 || req1) begin
                        win_id    <= sel_id;
                        win_wr    <= sel_wr;
                        win_addr  <= sel_addr;
                        win_wdata <= sel_wdata;
                        state     <= BUSY;
                        busy      <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!win_wr) begin
                        if (win_id == PORT1) begin
                            core1.rdata <= store_rdata;
                        end else begin
                            core0.rdata <= store_rdata;
                        end
                    end
                    if (win_id == PORT1) begin
                        core1.ack <= 1'b1;
`ifdef ARB_STATS_EN
                        if (grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 16'd1;
`endif
                    end else begin
                        core0.ack <= 1'b1;
`ifdef ARB_STATS_EN
                        if (grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 16'd1;
`endif
                    end
                    state <= ACK;
                end
                ACK: begin
                    core0.ack <= 1'b0;
                    core1.ack <= 1'b0;
                    rr_ptr    <= ~win_id;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    core0.ack <= 1'b0;
                    core1.ack <= 1'b0;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dual_core_data_arbiter.sv
// Scoreboard bench for dual_core_data_arbiter; grant counters are checked
// when ARB_STATS_EN is defined.
module tb_dual_core_data_arbiter;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    always #5 clk = ~clk;

    dual_core_data_arbiter_if #(.DATA_W(16), .ADDR_W(16)) c0 ();
    dual_core_data_arbiter_if #(.DATA_W(16), .ADDR_W(16)) c1 ();

    dual_core_data_arbiter #(
        .DATA_W     (16),
        .ADDR_W     (16),
        .DEPTH_LOG2 (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core0      (c0),
        .core1      (c1),
`ifdef ARB_STATS_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .busy       (busy)
    );

    typedef struct {
        bit          port;
        bit          is_wr;
        logic [15:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] model [256];
    logic [15:0] shadow [2];
    int unsigned grants [2];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive(input bit port, input bit rd, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (port) begin
            c1.rd = rd; c1.wr = wr; c1.addr = addr; c1.wdata = wdata;
        end else begin
            c0.rd = rd; c0.wr = wr; c0.addr = addr; c0.wdata = wdata;
        end
    endtask

    // Pushed in predicted grant order; the reference memory is updated here.
    task automatic issue(input bit port, input bit rd, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wdata);
        txn_t       e;
        logic [7:0] a;
        a = addr[7:0];
        drive(port, rd, wr, addr, wdata);
        e.port  = port;
        e.is_wr = wr;
        if (wr) model[a] = wdata;
        else    shadow[port] = model[a];
        e.data = shadow[port];
        exp_q.push_back(e);
    endtask

    task automatic expect_ack(input string tag);
        int          cyc;
        bit          seen;
        txn_t        e;
        logic [15:0] rd;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 12) begin
            @(negedge clk);
            cyc++;
            seen = c0.ack | c1.ack;
        end
        check_eq({tag, "_queued"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check_eq({tag, "_ack"}, {c1.ack, c0.ack}, e.port ? 2'b10 : 2'b01);
        check_eq({tag, "_lat"}, cyc, 3);
        rd = e.port ? c1.rdata : c0.rdata;
        check_eq({tag, "_rdata"}, rd, e.data);
        if (seen) grants[e.port]++;
        @(posedge clk);
        #1;
        drive(e.port, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check_eq({tag, "_idle"}, {c1.ack, c0.ack, busy}, 3'b000);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check_eq({tag, "_outs"}, {c0.rdata, c1.rdata, c0.ack, c1.ack, busy}, 35'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        shadow[0] = 16'h0;
        shadow[1] = 16'h0;
        grants[0] = 0;
        grants[1] = 0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        do_reset("reset0");

        // Single-port write then read-back.
        issue(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        expect_ack("w0");
        idle_check("w0");
        issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        expect_ack("r0");
        idle_check("r0");

        // Simultaneous reads: core 0 first after reset; core 0 re-requesting
        // while core 1 waits makes a second pair that core 1 wins.
        do_reset("reset1");
        issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        issue(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
        expect_ack("pair_a0");
        issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        expect_ack("pair_b1");
        expect_ack("pair_b0");
        idle_check("pair");

        // Cross-core coherence; a write leaves rdata0 alone.
        issue(1'b1, 1'b0, 1'b1, 16'h0005, 16'h1234);
        expect_ack("coh_w1");
        issue(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0);
        expect_ack("coh_r0");
        issue(1'b0, 1'b0, 1'b1, 16'h0005, 16'h5555);
        expect_ack("coh_w0");
        issue(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
        expect_ack("coh_r1");
        idle_check("coh");

        // Address wrap and rd+wr treated as write.
        issue(1'b0, 1'b0, 1'b1, 16'h0100, 16'hA5A5);
        expect_ack("wrap_w0");
        issue(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0);
        expect_ack("wrap_r1");
        issue(1'b0, 1'b1, 1'b1, 16'h0030, 16'h3C3C);
        expect_ack("rdwr_w0");
        issue(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0);
        expect_ack("rdwr_r1");
        idle_check("wrap");

        // Reset while a write sits in BUSY: no commit, no ack.
        issue(1'b0, 1'b0, 1'b1, 16'h0020, 16'h1111);
        expect_ack("pre_w0");
        issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
        expect_ack("pre_r0");
        drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'h7777);
        @(negedge clk);
        @(posedge clk);
        #1;
        check_eq("abort_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_eq("abort_outs", {c0.rdata, c1.rdata, c0.ack, c1.ack, busy}, 35'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check_eq("abort_noack", {c1.ack, c0.ack}, 2'b00);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        shadow[0] = 16'h0;
        shadow[1] = 16'h0;
        idle_check("abort");
        issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
        expect_ack("abort_r0");
        idle_check("abort_r0");

`ifdef ARB_STATS_EN
        do_reset("stats_rst");
        check_eq("stats_clr", {grant_cnt0, grant_cnt1}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 1'b0, 1'b1, 16'(16'h0040 + i), 16'(16'h0100 + i));
            expect_ack("stats_p0");
        end
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b1, 1'b0, 16'(16'h0040 + i), 16'h0);
            expect_ack("stats_p1");
        end
        idle_check("stats");
        check_eq("grant_cnt0", grant_cnt0, 16'd5);
        check_eq("grant_cnt1", grant_cnt1, 16'd3);
        check_eq("grant_cnt0_sb", grant_cnt0, grants[0]);
        check_eq("grant_cnt1_sb", grant_cnt1, grants[1]);
        do_reset("stats_rst2");
        check_eq("stats_clr2", {grant_cnt0, grant_cnt1}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
